// File: rtl/mod3_pkg.sv
// Shared types and constants for the bit-serial divisibility-by-3 engine.
// The residue enum doubles as the encoding of "value so far mod 3".
package mod3_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        R0 = 2'd0,
        R1 = 2'd1,
        R2 = 2'd2
    } res_e;

endpackage

// File: rtl/mod3_step.sv
// One MSB-first residue step: next = (2*res + bit) mod 3.
// Purely combinational; the top instantiates it once per scan position.
module mod3_step
    import mod3_pkg::*;
(
    input  res_e res_i,
    input  logic bit_i,
    output res_e res_o
);

    always_comb begin
        res_o = R0;
        unique case (res_i)
            R0:      res_o = bit_i ? R1 : R0;
            R1:      res_o = bit_i ? R0 : R2;
            R2:      res_o = bit_i ? R2 : R1;
            default: res_o = R0;
        endcase
    end

endmodule

// File: rtl/modulo3_aggregate.sv
// Captures an operand, scans it MSB-first and publishes the prefix-divisibility vector.
// Optional macro MOD3_DONE_EN adds a one-cycle 'done' pulse coincident with each out update.
module modulo3_aggregate
    import mod3_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
`ifdef MOD3_DONE_EN
    output logic             done,
`endif
    output logic [WIDTH-1:0] out
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] cap_q, cap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    res_e             res_q, res_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] out_q, out_d;

    logic [CNT_W-1:0] bitIdx;
    res_e             stepRes;

    // Bits are consumed MSB-first, so the counter maps to a descending index.
    assign bitIdx = LAST_CNT - cnt_q;

    mod3_step u_step (
        .res_i (res_q),
        .bit_i (cap_q[bitIdx]),
        .res_o (stepRes)
    );

`ifdef MOD3_DONE_EN
    logic done_q, done_d;
`endif

    always_comb begin
        cap_d  = cap_q;
        cnt_d  = cnt_q;
        res_d  = res_q;
        acc_d  = acc_q;
        busy_d = busy_q;
        out_d  = out_q;
`ifdef MOD3_DONE_EN
        done_d = 1'b0;
`endif
        // A new operand always wins, even on what would have been the completion edge.
        if (in != cap_q) begin
            cap_d  = in;
            res_d  = R0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            res_d         = stepRes;
            acc_d[bitIdx] = (stepRes == R0);
            cnt_d         = cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) begin
                out_d  = acc_d;
                busy_d = 1'b0;
`ifdef MOD3_DONE_EN
                done_d = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_q  <= '0;
            cnt_q  <= '0;
            res_q  <= R0;
            acc_q  <= '0;
            busy_q <= 1'b1;
            out_q  <= '0;
        end else begin
            cap_q  <= cap_d;
            cnt_q  <= cnt_d;
            res_q  <= res_d;
            acc_q  <= acc_d;
            busy_q <= busy_d;
            out_q  <= out_d;
        end
    end

`ifdef MOD3_DONE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
        end
    end

    assign done = done_q;
`endif

    assign out = out_q;

endmodule

// File: tb/tb_modulo3_aggregate.sv
// Scoreboard bench for modulo3_aggregate: stimulus queues expected results with due edges,
// a negedge monitor pops and compares them and checks that out holds otherwise.
module tb_modulo3_aggregate;

    logic       clk;
    logic       rst;
    logic [7:0] in;
    logic [7:0] out;
`ifdef MOD3_DONE_EN
    logic       done;
`endif

    modulo3_aggregate #(.WIDTH(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .in   (in),
`ifdef MOD3_DONE_EN
        .done (done),
`endif
        .out  (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] value;
        int         due;
    } exp_t;

    exp_t       sb[$];
    int         edgeCount = 0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] lastOut = 8'h00;
    logic [7:0] curIn = 8'h00;
    bit         monitorOn = 1'b0;

    always @(posedge clk) edgeCount <= edgeCount + 1;

    // Reference: bit i is set when the number formed by bits [7:i] is a multiple of 3.
    function automatic logic [7:0] refDiv(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = ((int'(v) >> i) % 3) == 0;
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %02h expected %02h at edge %0d", name, actual, expected, edgeCount);
        end
    endtask

    // Present v at a negedge and hold it for 'hold' negedges; a change kills any pending result.
    task automatic applyStimulus(input logic [7:0] v, input int hold);
        int m;
        @(negedge clk);
        m = edgeCount;
        if (v != curIn) begin
            while (sb.size() > 0 && sb[sb.size()-1].due > m) void'(sb.pop_back());
            sb.push_back('{refDiv(v), m + 9});
        end
        in    = v;
        curIn = v;
        repeat (hold - 1) @(negedge clk);
    endtask

    task automatic releaseReset();
        int m;
        @(negedge clk);
        rst = 1'b0;
        m = edgeCount;
        sb.push_back('{refDiv(curIn), (curIn == 8'h00) ? m + 8 : m + 9});
    endtask

    always @(negedge clk) begin
        if (monitorOn && !rst) begin
            logic doneExp;
            doneExp = 1'b0;
            while (sb.size() > 0 && sb[0].due < edgeCount) begin
                checkOutput("missed_result", out, sb[0].value);
                void'(sb.pop_front());
            end
            if (sb.size() > 0 && sb[0].due == edgeCount) begin
                checkOutput("result", out, sb[0].value);
                lastOut = sb[0].value;
                void'(sb.pop_front());
                doneExp = 1'b1;
            end else begin
                checkOutput("hold", out, lastOut);
            end
`ifdef MOD3_DONE_EN
            checkOutput("done", {7'd0, done}, {7'd0, doneExp});
`else
            if (doneExp) begin end
`endif
        end
    end

    initial begin
        logic [7:0] tv[6];
        tv = '{8'd6, 8'd7, 8'd45, 8'd96, 8'd100, 8'd255};
        rst = 1'b1;
        in  = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("reset_out", out, 8'h00);
`ifdef MOD3_DONE_EN
        checkOutput("reset_done", {7'd0, done}, 8'h00);
`endif
        monitorOn = 1'b1;
        releaseReset();
        repeat (10) @(negedge clk);
        checkOutput("first_scan_ff", out, 8'hFF);

        foreach (tv[i]) applyStimulus(tv[i], 12);

        // Mid-scan abort: 45 completes, a short-lived 7 and a 4-bit 45 scan never publish.
        applyStimulus(8'd45, 12);
        applyStimulus(8'd7, 2);
        applyStimulus(8'd45, 5);
        applyStimulus(8'd255, 12);

        // Change exactly on the completion edge: restart wins, no update for 6.
        applyStimulus(8'd6, 8);
        applyStimulus(8'd96, 12);

        for (int i = 0; i < 30; i++) begin
            applyStimulus(8'($urandom_range(0, 255)), $urandom_range(1, 14));
        end
        applyStimulus(8'd100, 12);

        // Asynchronous reset in the middle of a scan.
        applyStimulus(8'd45, 4);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_reset_out", out, 8'h00);
`ifdef MOD3_DONE_EN
        checkOutput("async_reset_done", {7'd0, done}, 8'h00);
`endif
        sb.delete();
        lastOut = 8'h00;
        repeat (2) @(negedge clk);
        releaseReset();
        repeat (11) @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            applyStimulus(8'($urandom_range(0, 255)), $urandom_range(6, 14));
        end
        applyStimulus(8'd255, 12);
        repeat (2) @(negedge clk);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending results expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
